// File: rtl/risc_pkg.sv
// Shared defaults for the RISC core datapath: register width, register
// address width and the register-count derivation.
package risc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  function automatic int unsigned nregs(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/risc_scoreboard.sv
// Pending-load scoreboard: one bit per register, raw busy lookup for two
// read ports, and a sticky flag for ALU writes that race a pending load.
module risc_scoreboard
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_dst,
  input  logic              ld_rtn_vld,
  input  logic [ADDR_W-1:0] ld_rtn_dst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              waw_err
);

  localparam int unsigned NREGS = nregs(ADDR_W);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             waw_err_q, waw_err_d;

  always_comb begin
    pending_d = pending_q;
    if (ld_rtn_vld) pending_d[ld_rtn_dst] = 1'b0;
    // Set after clear so a back-to-back load to the same register stays pending.
    if (ld_issue) pending_d[ld_issue_dst] = 1'b1;
    if (ZERO_R0) pending_d[0] = 1'b0;
  end

  // pending_q[0] is held at 0 when ZERO_R0, so R0 writes never flag here.
  assign waw_err_d = waw_err_q | (wr_vld & pending_q[wr_dst]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      waw_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      waw_err_q <= waw_err_d;
    end
  end

  assign busy_a  = pending_q[addr_a];
  assign busy_b  = pending_q[addr_b];
  assign waw_err = waw_err_q;

endmodule

// File: rtl/risc_regfile_sb.sv
// Two-write, two-read register file with optional write bypass, optional
// hardwired-zero R0 and a pending-load scoreboard driving the stall signal.
module risc_regfile_sb
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic [DATA_W-1:0] rslt,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_dst,
  input  logic              ld_rtn_vld,
  input  logic [ADDR_W-1:0] ld_rtn_dst,
  input  logic [DATA_W-1:0] dmdataout,
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  output logic [DATA_W-1:0] oprnd_a,
  output logic [DATA_W-1:0] oprnd_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic              waw_err
);

  localparam int unsigned NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              pend_a, pend_b;
  logic              fwd_a, fwd_b;

  always_comb begin
    regs_d = regs_q;
    if (wr_vld) regs_d[wr_dst] = rslt;
    // Load return is applied last so it wins a same-destination collision.
    if (ld_rtn_vld) regs_d[ld_rtn_dst] = dmdataout;
    if (ZERO_R0) regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    oprnd_a = regs_q[opnda_addr];
    oprnd_b = regs_q[opndb_addr];
    if (BYPASS) begin
      if (wr_vld && (wr_dst == opnda_addr)) oprnd_a = rslt;
      if (wr_vld && (wr_dst == opndb_addr)) oprnd_b = rslt;
      if (ld_rtn_vld && (ld_rtn_dst == opnda_addr)) oprnd_a = dmdataout;
      if (ld_rtn_vld && (ld_rtn_dst == opndb_addr)) oprnd_b = dmdataout;
    end
    if (ZERO_R0 && (opnda_addr == '0)) oprnd_a = '0;
    if (ZERO_R0 && (opndb_addr == '0)) oprnd_b = '0;
  end

  risc_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_vld       (wr_vld),
    .wr_dst       (wr_dst),
    .ld_issue     (ld_issue),
    .ld_issue_dst (ld_issue_dst),
    .ld_rtn_vld   (ld_rtn_vld),
    .ld_rtn_dst   (ld_rtn_dst),
    .addr_a       (opnda_addr),
    .addr_b       (opndb_addr),
    .busy_a       (pend_a),
    .busy_b       (pend_b),
    .waw_err      (waw_err)
  );

  // A returning load being forwarded this cycle no longer blocks the reader.
  assign fwd_a  = BYPASS && ld_rtn_vld && (ld_rtn_dst == opnda_addr);
  assign fwd_b  = BYPASS && ld_rtn_vld && (ld_rtn_dst == opndb_addr);
  assign busy_a = pend_a & ~fwd_a;
  assign busy_b = pend_b & ~fwd_b;
  assign stall  = busy_a | busy_b;

endmodule
